// File: rtl/axi_lite_reg_file_slave.sv
// AXI4-Lite slave register file: N_REGS software-visible registers with
// independent one-deep AW and W buffers, byte-strobed writes, per-register
// write pulses and a single outstanding read.
// Optional build macro: AXI_LITE_REG_FILE_SLVERR_EN makes out-of-range
// accesses answer SLVERR instead of OKAY.
module axi_lite_reg_file_slave #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 32,
   parameter int N_REGS         = 8,
   parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
   input  logic                             Clk_CI,
   input  logic                             Rst_RBI,
   input  logic [AXI_ADDR_WIDTH-1:0]        AwAddr_DI,
   input  logic                             AwValid_SI,
   output logic                             AwReady_SO,
   input  logic [AXI_DATA_WIDTH-1:0]        WData_DI,
   input  logic [AXI_DATA_WIDTH/8-1:0]      WStrb_DI,
   input  logic                             WValid_SI,
   output logic                             WReady_SO,
   output logic [1:0]                       BResp_DO,
   output logic                             BValid_SO,
   input  logic                             BReady_SI,
   input  logic [AXI_ADDR_WIDTH-1:0]        ArAddr_DI,
   input  logic                             ArValid_SI,
   output logic                             ArReady_SO,
   output logic [AXI_DATA_WIDTH-1:0]        RData_DO,
   output logic [1:0]                       RResp_DO,
   output logic                             RValid_SO,
   input  logic                             RReady_SI,
   output logic [N_REGS*AXI_DATA_WIDTH-1:0] Reg_DO,
   output logic [N_REGS-1:0]                RegWr_SO
);

   localparam int STRB_W     = AXI_DATA_WIDTH / 8;
   localparam int BYTE_SHIFT = $clog2(STRB_W);
   localparam int IDX_W      = $clog2(N_REGS);
   localparam int SPAN_SHIFT = BYTE_SHIFT + IDX_W;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef AXI_LITE_REG_FILE_SLVERR_EN
   localparam logic [1:0] RESP_OOR = RESP_SLVERR;
`else
   localparam logic [1:0] RESP_OOR = RESP_OKAY;
`endif

   // Offset from the base, one bit wider so an address below the base
   // shows up as a set borrow bit and therefore as out of range.
   function automatic logic [AXI_ADDR_WIDTH:0] addr_offset(input logic [AXI_ADDR_WIDTH-1:0] addr);
      return {1'b0, addr} - {1'b0, BASE_ADDR};
   endfunction

   function automatic logic addr_in_range(input logic [AXI_ADDR_WIDTH-1:0] addr);
      logic [AXI_ADDR_WIDTH:0] off;
      off = addr_offset(addr);
      return (off >> SPAN_SHIFT) == '0;
   endfunction

   // Byte-offset bits below the word are discarded by the shift.
   function automatic logic [IDX_W-1:0] addr_idx(input logic [AXI_ADDR_WIDTH-1:0] addr);
      logic [AXI_ADDR_WIDTH:0] off;
      off = addr_offset(addr);
      return IDX_W'(off >> BYTE_SHIFT);
   endfunction

   function automatic logic [AXI_DATA_WIDTH-1:0] apply_strb(input logic [AXI_DATA_WIDTH-1:0] old_v,
                                                            input logic [AXI_DATA_WIDTH-1:0] new_v,
                                                            input logic [STRB_W-1:0]         strb);
      logic [AXI_DATA_WIDTH-1:0] res;
      res = old_v;
      for (int b = 0; b < STRB_W; b++) begin
         if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
      end
      return res;
   endfunction

   logic                      aw_held;
   logic                      w_held;
   logic [AXI_ADDR_WIDTH-1:0] aw_addr_q;
   logic [AXI_DATA_WIDTH-1:0] w_data_q;
   logic [STRB_W-1:0]         w_strb_q;
   logic                      b_valid;
   logic [1:0]                b_resp;
   logic                      r_valid;
   logic [AXI_DATA_WIDTH-1:0] r_data;
   logic [1:0]                r_resp;
   logic [AXI_DATA_WIDTH-1:0] regs_q [N_REGS];
   logic [N_REGS-1:0]         reg_wr_q;

   logic                      aw_fire;
   logic                      w_fire;
   logic                      ar_fire;
   logic                      commit;
   logic                      wr_in_range;
   logic [IDX_W-1:0]          wr_idx;
   logic                      rd_in_range;
   logic [IDX_W-1:0]          rd_idx;

   assign AwReady_SO = !aw_held;
   assign WReady_SO  = !w_held;
   assign ArReady_SO = !r_valid;

   assign aw_fire = AwValid_SI && !aw_held;
   assign w_fire  = WValid_SI && !w_held;
   assign ar_fire = ArValid_SI && !r_valid;

   // A write commits only once both halves are buffered and the previous
   // response has been taken, so B never has two responses in flight.
   assign commit      = aw_held && w_held && !b_valid;
   assign wr_in_range = addr_in_range(aw_addr_q);
   assign wr_idx      = addr_idx(aw_addr_q);
   assign rd_in_range = addr_in_range(ArAddr_DI);
   assign rd_idx      = addr_idx(ArAddr_DI);

   assign BValid_SO = b_valid;
   assign BResp_DO  = b_resp;
   assign RValid_SO = r_valid;
   assign RData_DO  = r_data;
   assign RResp_DO  = r_resp;
   assign RegWr_SO  = reg_wr_q;

   for (genvar i = 0; i < N_REGS; i++) begin : g_pack
      assign Reg_DO[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = regs_q[i];
   end

   // Channel-held flags and the write response.
   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         aw_held <= 1'b0;
         w_held  <= 1'b0;
         b_valid <= 1'b0;
         b_resp  <= RESP_OKAY;
      end else begin
         if (aw_fire)     aw_held <= 1'b1;
         else if (commit) aw_held <= 1'b0;
         if (w_fire)      w_held  <= 1'b1;
         else if (commit) w_held  <= 1'b0;
         if (commit) begin
            b_valid <= 1'b1;
            b_resp  <= wr_in_range ? RESP_OKAY : RESP_OOR;
         end else if (b_valid && BReady_SI) begin
            b_valid <= 1'b0;
         end
      end
   end

   // Address and write-data buffers; only meaningful while their flag is set.
   always_ff @(posedge Clk_CI) begin
      if (aw_fire) aw_addr_q <= AwAddr_DI;
      if (w_fire) begin
         w_data_q <= WData_DI;
         w_strb_q <= WStrb_DI;
      end
   end

   // Register bank update and one-cycle write pulse on an in-range commit.
   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         for (int i = 0; i < N_REGS; i++) regs_q[i] <= '0;
         reg_wr_q <= '0;
      end else begin
         reg_wr_q <= '0;
         if (commit && wr_in_range) begin
            regs_q[wr_idx]   <= apply_strb(regs_q[wr_idx], w_data_q, w_strb_q);
            reg_wr_q[wr_idx] <= 1'b1;
         end
      end
   end

   // Read response: captures the pre-edge register value, held until taken.
   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_resp  <= RESP_OKAY;
      end else if (ar_fire) begin
         r_valid <= 1'b1;
         r_data  <= rd_in_range ? regs_q[rd_idx] : '0;
         r_resp  <= rd_in_range ? RESP_OKAY : RESP_OOR;
      end else if (r_valid && RReady_SI) begin
         r_valid <= 1'b0;
      end
   end

endmodule
